// File: rtl/midi_voice_allocator_pkg.sv
// midi_voice_allocator_pkg: shared FSM encoding and note width for the voice allocator
package midi_voice_allocator_pkg;
  localparam int note_w = 7;
  typedef enum logic [1:0] {IDLE, SCAN, ASSIGN, RELEASE} state_t;
endpackage

// File: rtl/midi_voice_slot.sv
// midi_voice_slot: one voice's note, gate and saturating age
module midi_voice_slot
  import midi_voice_allocator_pkg::*;
#(
  parameter int age_bits = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic                clr,
  input  logic                inc,
  input  logic [note_w-1:0]   note_in,
  output logic [note_w-1:0]   note,
  output logic                gate,
  output logic [age_bits-1:0] age
);
  // a write (re)starts the voice; otherwise release gate and age active voices
  always_ff @(posedge clk) begin
    if (rst) begin
      note <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (wr) begin
      note <= note_in;
      gate <= 1'b1;
      age  <= '0;
    end else begin
      if (clr) gate <= 1'b0;
      if (inc && gate && age != '1) age <= age + 1'b1;
    end
  end
endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: assigns NoteOn/NoteOff events to voices with retrigger, free-pick and oldest-steal
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int pChannel = 4,
  parameter int pAgeBits = 8
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic [note_w-1:0]          iNoteNumber,
  input  logic                       iNoteOn,
  input  logic                       iNoteOff,
  output logic                       oReady,
  output logic [pChannel*note_w-1:0] oNoteNumber,
  output logic [pChannel-1:0]        oNoteOn,
  output logic                       oSteal,
  output logic                       oDrop
);
  localparam int IW = $clog2(pChannel);
  state_t state, nxt;
  logic [IW-1:0] idx, m_idx, f_idx, o_idx, target;
  logic m_found, f_found, accept;
  logic [pAgeBits-1:0] o_age;
  logic [note_w-1:0] note_l;
  logic [note_w-1:0] note_a [pChannel];
  logic [pAgeBits-1:0] age_a [pChannel];
  assign oReady = state == IDLE;
  assign accept = oReady && (iNoteOn || iNoteOff);
  assign target = m_found ? m_idx : f_found ? f_idx : o_idx;
  // next state: NoteOff wins over NoteOn; scan walks every voice once
  always_comb begin
    nxt = state == IDLE ? (iNoteOff ? RELEASE : iNoteOn ? SCAN : IDLE) :
          state == SCAN ? (idx == IW'(pChannel - 1) ? ASSIGN : SCAN) : IDLE;
  end
  // state register
  always_ff @(posedge iCLK) begin
    state <= iRST ? IDLE : nxt;
  end
  // event latch, per-voice scan bookkeeping and status pulses
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      idx     <= '0;
      m_idx   <= '0;
      f_idx   <= '0;
      o_idx   <= '0;
      m_found <= 1'b0;
      f_found <= 1'b0;
      o_age   <= '0;
      note_l  <= '0;
      oSteal  <= 1'b0;
      oDrop   <= 1'b0;
    end else begin
      oSteal <= state == ASSIGN && !m_found && !f_found;
      oDrop  <= (iNoteOn || iNoteOff) && (!oReady || (iNoteOn && iNoteOff));
      if (accept) begin
        note_l  <= iNoteNumber;
        idx     <= '0;
        m_found <= 1'b0;
        f_found <= 1'b0;
        o_idx   <= '0;
        o_age   <= '0;
      end else if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (!m_found && oNoteOn[idx] && note_a[idx] == note_l) begin
          m_found <= 1'b1;
          m_idx   <= idx;
        end
        if (!f_found && !oNoteOn[idx]) begin
          f_found <= 1'b1;
          f_idx   <= idx;
        end
        if (oNoteOn[idx] && age_a[idx] > o_age) begin
          o_idx <= idx;
          o_age <= age_a[idx];
        end
      end
    end
  end
  for (genvar x = 0; x < pChannel; x++) begin : g_slot
    midi_voice_slot #(.age_bits(pAgeBits)) u_slot (
      .clk    (iCLK),
      .rst    (iRST),
      .wr     (state == ASSIGN && target == IW'(x)),
      .clr    (state == RELEASE && note_a[x] == note_l),
      .inc    (state == ASSIGN),
      .note_in(note_l),
      .note   (note_a[x]),
      .gate   (oNoteOn[x]),
      .age    (age_a[x])
    );
    assign oNoteNumber[note_w*x +: note_w] = note_a[x];
  end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: randomized scoreboard bench against a behavioural voice model
module tb_midi_voice_allocator;
  logic clk = 1'b0, rst = 1'b1, on = 1'b0, off = 1'b0;
  logic [6:0] nn = '0;
  logic ready, steal, drop;
  logic [27:0] notes;
  logic [3:0] gates;

  midi_voice_allocator dut (
    .iCLK(clk), .iRST(rst), .iNoteNumber(nn), .iNoteOn(on), .iNoteOff(off),
    .oReady(ready), .oNoteNumber(notes), .oNoteOn(gates), .oSteal(steal), .oDrop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] notes;
    logic [3:0]  gates;
    logic        steal;
    int          drops;
    logic [31:0] ages;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, drops_seen = 0, drops_exp = 0;
  logic [6:0] m_note[4];
  bit m_gate[4];
  int m_age[4];
  bit prev_ready = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_ages();
    return {dut.g_slot[3].u_slot.age, dut.g_slot[2].u_slot.age,
            dut.g_slot[1].u_slot.age, dut.g_slot[0].u_slot.age};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_note[i] = '0;
      m_gate[i] = 1'b0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_on(input logic [6:0] n, output bit st);
    int t = -1;
    st = 1'b0;
    for (int i = 0; i < 4; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
    for (int i = 0; i < 4; i++) if (t < 0 && !m_gate[i]) t = i;
    if (t < 0) begin
      st = 1'b1;
      t = 0;
      for (int i = 1; i < 4; i++) if (m_age[i] > m_age[t]) t = i;
    end
    for (int i = 0; i < 4; i++) if (i != t && m_gate[i] && m_age[i] < 255) m_age[i]++;
    m_note[t] = n;
    m_gate[t] = 1'b1;
    m_age[t]  = 0;
  endtask

  task automatic model_off(input logic [6:0] n);
    for (int i = 0; i < 4; i++) if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
  endtask

  task automatic snap(input string name, input bit st, input int lat, output exp_t e);
    e.name  = name;
    e.steal = st;
    e.lat   = lat;
    e.drops = drops_exp;
    e.t0    = cyc;
    for (int i = 0; i < 4; i++) begin
      e.notes[7*i +: 7] = m_note[i];
      e.gates[i]        = m_gate[i];
      e.ages[8*i +: 8]  = m_age[i][7:0];
    end
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: ready=%b required 1", name, ready);
    end
  endtask

  task automatic ev(input bit o, input bit f, input logic [6:0] n, input bit busy);
    exp_t e;
    bit st = 1'b0;
    string name;
    if (f) model_off(n);
    else if (o) model_on(n, st);
    if (o && f) drops_exp++;
    if (busy) drops_exp++;
    name = $sformatf("ev_n%0d_on%0d_off%0d_busy%0d", n, o, f, busy);
    @(negedge clk);
    snap(name, st, f ? 2 : 6, e);
    q.push_back(e);
    on = o; off = f; nn = n;
    @(negedge clk);
    on = 1'b0; off = 1'b0;
    if (busy) begin
      on = 1'b1; nn = n ^ 7'h15;
      @(negedge clk);
      on = 1'b0;
    end
    wait_ready(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic reset_in_scan();
    exp_t e;
    model_reset();
    @(negedge clk);
    snap("rst_scan", 1'b0, -1, e);
    q.push_back(e);
    on = 1'b1; nn = 7'd60;
    @(negedge clk);
    on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("rst_scan");
  endtask

  // scoreboard monitor: each return of oReady completes the oldest pending event
  always @(negedge clk) begin : mon
    exp_t e;
    if (drop) drops_seen++;
    if (ready && !prev_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_completion: got completion required none");
      end else begin
        e = q.pop_front();
        check({e.name, "_notes"}, 64'(notes), 64'(e.notes));
        check({e.name, "_gates"}, 64'(gates), 64'(e.gates));
        check({e.name, "_steal"}, 64'(steal), 64'(e.steal));
        check({e.name, "_drops"}, 64'(drops_seen), 64'(e.drops));
        check({e.name, "_ages"}, 64'(dut_ages()), 64'(e.ages));
        if (e.lat >= 0) check({e.name, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
      end
    end else if (steal) begin
      tests++;
      fails++;
      $display("FAIL stray_steal: got 1 required 0");
    end
    prev_ready = ready;
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_gates", 64'(gates), 64'd0);
    check("reset_notes", 64'(notes), 64'd0);
    check("reset_steal", 64'(steal), 64'd0);
    check("reset_drop", 64'(drop), 64'd0);
    check("reset_ages", 64'(dut_ages()), 64'd0);
    ev(1, 0, 60, 0);
    ev(1, 0, 62, 0);
    ev(1, 0, 64, 0);
    ev(1, 0, 65, 0);
    ev(1, 0, 67, 0);
    do_reset();
    ev(1, 0, 60, 0);
    ev(1, 0, 60, 0);
    ev(0, 1, 60, 0);
    ev(0, 1, 70, 0);
    ev(1, 0, 62, 0);
    ev(1, 1, 62, 0);
    ev(1, 0, 64, 1);
    ev(1, 0, 66, 0);
    reset_in_scan();
    ev(1, 0, 1, 0);
    ev(1, 0, 2, 0);
    ev(1, 0, 3, 0);
    repeat (300) ev(1, 0, 1, 0);
    do_reset();
    repeat (80) begin
      int k = $urandom_range(0, 9);
      logic [6:0] n = 7'(60 + $urandom_range(0, 7));
      if (k < 5) ev(1, 0, n, 0);
      else if (k < 7) ev(0, 1, n, 0);
      else if (k == 7) ev(1, 1, n, 0);
      else ev(1, 0, n, 1);
    end
    repeat (4) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    check("total_drops", 64'(drops_seen), 64'(drops_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
